// File: rtl/fifo_rd_ctrl_if.sv
// Read-side FIFO bundle: write-pointer crossing, fifomem read port,
// the downstream valid/ready stream and the occupancy/status flags.
interface fifo_rd_ctrl_if #(
  parameter int DATASIZE = 8,
  parameter int ADDRSIZE = 4
);
  logic [ADDRSIZE:0]   rwptr;
  logic [ADDRSIZE:0]   rptr;
  logic [ADDRSIZE-1:0] raddr;
  logic                rclken;
  logic [DATASIZE-1:0] rdata_mem;
  logic                m_valid;
  logic                m_ready;
  logic [DATASIZE-1:0] m_data;
  logic                rempty;
  logic                raempty;
  logic [ADDRSIZE:0]   rlevel;

  // master: the read controller; slave: memory, write side and consumer
  modport master (
    input  rwptr, rdata_mem, m_ready,
    output rptr, raddr, rclken, m_valid, m_data, rempty, raempty, rlevel
  );

  modport slave (
    output rwptr, rdata_mem, m_ready,
    input  rptr, raddr, rclken, m_valid, m_data, rempty, raempty, rlevel
  );
endinterface

// File: rtl/fifo_rd_ctrl.sv
// Read-domain controller for the dual-clock FIFO: synchronises the Gray write
// pointer, owns the read pointer and flags, and streams words out of fifomem.
module fifo_rd_ctrl #(
  parameter int DATASIZE     = 8,
  parameter int ADDRSIZE     = 4,
  parameter int AEMPTY_LEVEL = 1
) (
  input  logic           rclk,
  input  logic           rrst,
  fifo_rd_ctrl_if.master bus
);
  localparam int PW = ADDRSIZE + 1;
  localparam logic [PW-1:0] AEMPTY_THR = PW'(AEMPTY_LEVEL);

  logic [PW-1:0]       rq1_wptr_reg;
  logic [PW-1:0]       rq2_wptr_reg;
  logic [PW-1:0]       rbin_reg;
  logic [PW-1:0]       rptr_reg;
  logic                rempty_reg;
  logic                m_valid_reg;

  logic                pop;
  logic                m_valid_next;
  logic [PW-1:0]       rbin_next;
  logic [PW-1:0]       rgray_next;
  logic [PW-1:0]       wbin_s;
  logic [PW-1:0]       rlevel;
  logic [DATASIZE-1:0] word;

  // Two-flop crossing; rwptr is sampled nowhere else.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      rq1_wptr_reg <= '0;
      rq2_wptr_reg <= '0;
    end else begin
      rq1_wptr_reg <= bus.rwptr;
      rq2_wptr_reg <= rq1_wptr_reg;
    end
  end

  // A new word is fetched only when the output slot is free or draining now.
  assign pop        = !rempty_reg && (!m_valid_reg || bus.m_ready);
  assign rbin_next  = rbin_reg + PW'(pop);
  assign rgray_next = (rbin_next >> 1) ^ rbin_next;

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      rbin_reg   <= '0;
      rptr_reg   <= '0;
      rempty_reg <= 1'b1;
    end else begin
      rbin_reg   <= rbin_next;
      rptr_reg   <= rgray_next;
      rempty_reg <= (rgray_next == rq2_wptr_reg);
    end
  end

  always_comb begin
    m_valid_next = m_valid_reg;
    if (pop) begin
      m_valid_next = 1'b1;
    end else if (bus.m_ready) begin
      m_valid_next = 1'b0;
    end
  end

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      m_valid_reg <= 1'b0;
    end else begin
      m_valid_reg <= m_valid_next;
    end
  end

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
  generate
    for (genvar gi = 0; gi < PW; gi++) begin : g_g2b
      assign wbin_s[gi] = ^rq2_wptr_reg[PW-1:gi];
    end
  endgenerate

  assign rlevel = wbin_s - rbin_reg;

  // fifomem's registered output only moves on a pop, so it doubles as the
  // output holding register while the consumer stalls.
  assign word = bus.rdata_mem;

  assign bus.rptr    = rptr_reg;
  assign bus.raddr   = rbin_reg[ADDRSIZE-1:0];
  assign bus.rclken  = pop;
  assign bus.m_valid = m_valid_reg;
  assign bus.m_data  = word;
  assign bus.rempty  = rempty_reg;
  assign bus.rlevel  = rlevel;
  assign bus.raempty = (rlevel <= AEMPTY_THR);
endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: registered-read memory model, scoreboard of written
// words drained by a negedge monitor, plus timed checks of flags and pointers.
module tb_fifo_rd_ctrl;
  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;

  logic rclk = 1'b0;
  logic rrst = 1'b1;

  int vectors     = 0;
  int miscompares = 0;

  fifo_rd_ctrl_if #(.DATASIZE(DW), .ADDRSIZE(AW)) bus ();

  fifo_rd_ctrl #(
    .DATASIZE    (DW),
    .ADDRSIZE    (AW),
    .AEMPTY_LEVEL(1)
  ) dut (
    .rclk(rclk),
    .rrst(rrst),
    .bus (bus)
  );

  always #5 rclk = ~rclk;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] exp_q [$];
  int  wcount       = 0;
  int  hs_count     = 0;
  int  hs_total     = 0;
  int  rclken_count = 0;
  bit  raddr_wrap_seen = 0;
  bit  rptr_wrap_seen  = 0;

  // fifomem with registered read
  always @(posedge rclk) begin
    if (bus.rclken) bus.rdata_mem <= mem[bus.raddr];
  end

  function automatic logic [AW:0] gray(input int n);
    logic [AW:0] b;
    b = (AW+1)'(n);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge rclk);
    #1;
  endtask

  task automatic put(input logic [DW-1:0] d);
    mem[wcount % DEPTH] = d;
    exp_q.push_back(d);
    wcount++;
  endtask

  task automatic publish();
    bus.rwptr = gray(wcount);
  endtask

  task automatic do_reset();
    rrst      = 1'b1;
    bus.rwptr = '0;
    wcount    = 0;
    hs_total  = 0;
    exp_q.delete();
    step();
    step();
    rrst = 1'b0;
  endtask

  task automatic wait_nonempty(input string name);
    for (int n = 0; n < 10; n++) begin
      if (!bus.rempty) break;
      step();
    end
    check(name, bus.rempty, 0);
  endtask

  // Monitor: drains the scoreboard on every accepted word and checks hold-under-stall.
  initial begin
    bit          stall_prev = 0;
    logic [DW-1:0] stall_data = '0;
    logic [AW-1:0] last_pop_addr = '0;
    logic [AW:0]   prev_rptr = '0;
    logic [DW-1:0] e;
    forever begin
      @(negedge rclk);
      if (rrst) begin
        stall_prev    = 0;
        last_pop_addr = '0;
        prev_rptr     = '0;
      end else begin
        if (bus.rclken) begin
          rclken_count++;
          if (last_pop_addr == AW'(DEPTH-1) && bus.raddr == '0) raddr_wrap_seen = 1;
          last_pop_addr = bus.raddr;
        end
        if (prev_rptr == (AW+1)'(1 << AW) && bus.rptr == '0) rptr_wrap_seen = 1;
        prev_rptr = bus.rptr;
        if (stall_prev) begin
          check("stall_valid", bus.m_valid, 1);
          check("stall_data", bus.m_data, stall_data);
        end
        if (bus.m_valid && bus.m_ready) begin
          hs_count++;
          hs_total++;
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_word: actual=%0h required=none", bus.m_data);
          end else begin
            e = exp_q.pop_front();
            check("m_data", bus.m_data, e);
          end
        end
        stall_prev = bus.m_valid && !bus.m_ready;
        stall_data = bus.m_data;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int written;
    bus.rwptr   = '0;
    bus.m_ready = 1'b0;
    rrst        = 1'b1;
    step();
    step();

    // reset state
    check("rst_rempty", bus.rempty, 1);
    check("rst_raempty", bus.raempty, 1);
    check("rst_m_valid", bus.m_valid, 0);
    check("rst_rlevel", bus.rlevel, 0);
    check("rst_rptr", bus.rptr, 0);
    rrst = 1'b0;
    rclken_count = 0;
    repeat (10) step();
    check("idle_rempty", bus.rempty, 1);
    check("idle_raempty", bus.raempty, 1);
    check("idle_m_valid", bus.m_valid, 0);
    check("idle_rlevel", bus.rlevel, 0);
    check("idle_rclken", rclken_count, 0);

    // single word: visible 3 edges after rwptr moves, then 1-cycle latency
    bus.m_ready = 1'b1;
    put(8'hA5);
    publish();
    step();
    check("single_e1_rempty", bus.rempty, 1);
    step();
    check("single_e2_rempty", bus.rempty, 1);
    step();
    check("single_e3_rempty", bus.rempty, 0);
    check("single_rclken", bus.rclken, 1);
    check("single_raddr", bus.raddr, 0);
    step();
    check("single_m_valid", bus.m_valid, 1);
    check("single_m_data", bus.m_data, 8'hA5);
    check("single_rclken_off", bus.rclken, 0);
    check("single_rempty_back", bus.rempty, 1);
    check("single_rptr", bus.rptr, 1);
    step();
    check("single_m_valid_drop", bus.m_valid, 0);

    // full-depth burst at full rate
    do_reset();
    bus.m_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) put(DW'(i));
    publish();
    hs_count = 0;
    wait_nonempty("burst_wait");
    for (int k = 0; k <= DEPTH; k++) begin
      check("burst_rlevel", bus.rlevel, DEPTH - k);
      check("burst_raempty", bus.raempty, (DEPTH - k) <= 1);
      check("burst_rclken", bus.rclken, k < DEPTH);
      check("burst_m_valid", bus.m_valid, k >= 1);
      if (k < DEPTH) step();
    end
    step();
    step();
    check("burst_count", hs_count, DEPTH);
    check("burst_m_valid_end", bus.m_valid, 0);
    check("burst_rptr", bus.rptr, 8'h18);

    // backpressure: one fetch, frozen output, then full-rate drain
    bus.m_ready  = 1'b0;
    rclken_count = 0;
    for (int i = 0; i < 4; i++) put(DW'(8'h40 + i));
    publish();
    for (int s = 1; s <= 14; s++) begin
      step();
      if (s >= 5) begin
        check("bp_m_valid", bus.m_valid, 1);
        check("bp_m_data", bus.m_data, 8'h40);
      end
    end
    check("bp_rclken_count", rclken_count, 1);
    check("bp_rlevel", bus.rlevel, 3);
    check("bp_rempty", bus.rempty, 0);
    check("bp_raempty", bus.raempty, 0);
    hs_count    = 0;
    bus.m_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      check("bp_drain_valid", bus.m_valid, 1);
      step();
    end
    check("bp_drain_count", hs_count, 4);
    check("bp_drain_end", bus.m_valid, 0);

    // randomized traffic across the pointer wrap
    raddr_wrap_seen = 0;
    rptr_wrap_seen  = 0;
    written = 0;
    for (int c = 0; c < 3000; c++) begin
      bus.m_ready = ($urandom_range(0, 3) != 0);
      if (written < 40 && (wcount - hs_total) < DEPTH && $urandom_range(0, 1) == 1) begin
        put(DW'($urandom_range(0, 255)));
        publish();
        written++;
      end
      if (written == 40 && exp_q.size() == 0 && !bus.m_valid && bus.rempty) break;
      step();
    end
    check("wrap_drained", exp_q.size(), 0);
    check("wrap_written", written, 40);
    check("wrap_raddr", raddr_wrap_seen, 1);
    check("wrap_rptr_seen", rptr_wrap_seen, 1);
    check("wrap_rptr_final", bus.rptr, gray(wcount));
    check("wrap_rlevel", bus.rlevel, 0);

    // asynchronous reset while a word is held
    bus.m_ready = 1'b0;
    for (int i = 0; i < 5; i++) put(DW'(8'h60 + i));
    publish();
    for (int n = 0; n < 10; n++) begin
      if (bus.m_valid) break;
      step();
    end
    check("mrst_pre_valid", bus.m_valid, 1);
    #2;
    rrst      = 1'b1;
    bus.rwptr = '0;
    #1;
    check("mrst_m_valid", bus.m_valid, 0);
    check("mrst_rempty", bus.rempty, 1);
    check("mrst_rptr", bus.rptr, 0);
    exp_q.delete();
    wcount   = 0;
    hs_total = 0;
    step();
    rrst = 1'b0;
    rclken_count = 0;
    bus.m_ready  = 1'b1;
    repeat (10) step();
    check("mrst_after_rempty", bus.rempty, 1);
    check("mrst_after_valid", bus.m_valid, 0);
    check("mrst_after_rclken", rclken_count, 0);
    check("mrst_after_rlevel", bus.rlevel, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/fifo_rd_ctrl.md
Name: fifo_rd_ctrl

Overview:
- Read-side controller for the dual-clock FIFO built around fifomem. It runs entirely in the read clock domain.
- It synchronises the Gray-coded write pointer from the write domain and maintains the read pointer, empty and almost-empty flags.
- It drives fifomem's read address and read enable, with fifomem configured for registered read (FALLTHROUGH="FALSE").
- It presents popped words on a valid/ready stream to the downstream consumer, such as the FNV hasher input path.

Parameters:
- DATASIZE, 8, data word width; must match fifomem.
- ADDRSIZE, 4, memory address bits; FIFO depth is 2^ADDRSIZE.
- AEMPTY_LEVEL, 1, raempty asserts when occupancy <= this value.

Ports:
- rclk  in  1  read-domain clock.
- rrst  in  1  asynchronous, active-high reset.
- rwptr  in  ADDRSIZE+1  Gray-coded write pointer from the write domain; asynchronous to rclk.
- rptr  out  ADDRSIZE+1  Gray-coded read pointer, registered, for synchronisation into the write domain.
- raddr  out  ADDRSIZE  fifomem read address.
- rclken  out  1  fifomem read enable; high for exactly one cycle per pop.
- rdata_mem  in  DATASIZE  fifomem rdata (registered read output).
- m_valid  out  1  output word valid.
- m_ready  in  1  consumer accepts the word.
- m_data  out  DATASIZE  output word.
- rempty  out  1  FIFO empty flag, registered.
- raempty  out  1  almost-empty flag.
- rlevel  out  ADDRSIZE+1  occupancy as seen from the read side.

Behaviour:
- Reset: rrst asynchronously clears all state.
  - rbin, rptr, and both synchroniser stages go to 0.
  - rempty=1, m_valid=0, rlevel=0, raempty=1.
  - Reset is effective immediately mid-stream: any in-flight word is discarded and m_valid drops in the same cycle.
- Synchroniser: two-flop synchroniser on rwptr produces rq1_wptr and then rq2_wptr.
  - No other logic samples rwptr directly.
- Pop condition:
  - pop = !rempty && (!m_valid || m_ready).
  - rclken = pop.
  - raddr = rbin[ADDRSIZE-1:0] (current binary read pointer).
- Pointers:
  - rbinnext = rbin + pop, an (ADDRSIZE+1)-bit counter with natural wrap.
  - rgraynext = (rbinnext>>1) ^ rbinnext.
  - rbin <= rbinnext and rptr <= rgraynext every cycle.
  - The MSB distinguishes wrap laps: 2*DEPTH pops return the pointer to 0.
- Empty flag:
  - rempty <= (rgraynext == rq2_wptr).
  - The flag is conservative: a newly written word becomes visible 3 rclk edges after rwptr changes (2 synchroniser edges + 1 flag edge).
  - The flag is never falsely deasserted.
- Output stage:
  - fifomem updates rdata_mem on the edge where rclken=1.
  - m_valid <= 1 if pop; else 0 if m_ready; else hold.
  - m_data = rdata_mem, combinational passthrough.
  - This is valid because rclken never fires while a word is held unaccepted (pop requires !m_valid || m_ready).
  - While m_valid && !m_ready, m_data is stable.
  - Sustained throughput is one word per cycle when m_ready=1 and the FIFO is non-empty.
  - Pop-to-m_valid latency is 1 cycle.
- Level:
  - rq2_wptr is Gray-to-binary converted to give wbin_s.
  - rlevel = wbin_s - rbin, modulo 2^(ADDRSIZE+1).
  - raempty = (rlevel <= AEMPTY_LEVEL).
  - Both are combinational from registers only.
- Simultaneous events:
  - A consumer acceptance and a new pop in the same cycle keep m_valid=1 and present the new word next cycle.
  - A write arriving while the last word is popped leaves rempty=1 for the synchroniser latency, then rempty clears.
- Illegal input: rwptr must differ from the synchronised read-side view by at most DEPTH; otherwise behaviour is undefined and the bench does not test it.

Test Plan:
- Reset then idle, rwptr=0:
  - Required: rempty=1, raempty=1, m_valid=0, rclken never asserts, rlevel=0.
- Single word: bench memory model (registered read) holds 0xA5 at addr 0; step rwptr 0 -> Gray(1)=1.
  - Required: rempty falls 3 edges later; rclken pulses once with raddr=0; next cycle m_valid=1, m_data=0xA5.
  - With m_ready=1, m_valid drops the following cycle; rempty returns to 1; rptr=1.
- Burst: preload 16 words 0x00..0x0F; set rwptr=Gray(16)=0x18; hold m_ready=1.
  - Required: 16 consecutive m_valid cycles carrying 0x00..0x0F in order.
  - rlevel counts down 16..0; raempty asserts when rlevel=1; final rptr=0x18.
- Backpressure: with 4 words queued, hold m_ready=0 for 10 cycles.
  - Required: m_valid=1 and m_data frozen at the first word, with exactly one rclken pulse.
  - On releasing m_ready, the remaining words stream at one per cycle.
- Wrap-around: push and pop 40 words total through a depth-16 FIFO.
  - Required: raddr wraps 15 -> 0; rbin wraps 31 -> 0; data order preserved; rptr passes 0x10 (Gray(31)) -> 0x00.
- Reset mid-stream: assert rrst while m_valid=1 with 5 words queued.
  - Required: m_valid=0 and rempty=1 immediately (asynchronously); rptr=0.
  - After release with rwptr reset to 0, the controller stays empty.
